// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared unified memory.
// Fetch and load/store alternate on ties; each access holds the memory for MEM_LAT cycles.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic [1:0]  mem_write,
  output logic [11:0] mem_addr,
  output logic [31:0] bus_out,
  output logic        bus_oe,
  input  logic [31:0] bus_in,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        mem_read_q, mem_read_d;
  logic [1:0]  mem_write_q, mem_write_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [31:0] bus_out_q, bus_out_d;
  logic        bus_oe_q, bus_oe_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic        pick_d;

  // grant_q / last_grant_q: 1 = data port, 0 = fetch port
  assign pick_d = d_req && (!if_req || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    bus_out_d    = bus_out_q;
    bus_oe_d     = bus_oe_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d      = S_ACCESS;
          cnt_d        = CNT_INIT;
          grant_d      = pick_d;
          last_grant_d = pick_d;
          busy_d       = 1'b1;
          mem_addr_d   = pick_d ? d_addr : if_addr;
          if (pick_d && d_we) begin
            mem_read_d  = 1'b0;
            mem_write_d = d_byte ? 2'd3 : 2'd1;
            bus_out_d   = d_wdata;
            bus_oe_d    = 1'b1;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 2'd0;
            bus_oe_d    = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (mem_read_q) begin
            if (grant_q) d_rdata_d = bus_in;
            else         if_rdata_d = bus_in;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 2'd0;
          bus_oe_d    = 1'b0;
          if_ack_d    = !grant_q;
          d_ack_d     = grant_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
      grant_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 2'd0;
      mem_addr_q   <= 12'd0;
      bus_out_q    <= 32'd0;
      bus_oe_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: emulated memory plus a transaction-level model
// that predicts grant order, window contents, ack timing and read data.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = 12'd0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_byte = 1'b0;
  logic [11:0] d_addr = 12'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [11:0] mem_addr;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic [31:0] bus_in;
  logic        busy;

  logic        if2_req = 1'b0;
  logic [11:0] if2_addr = 12'd0;
  logic        if2_ack;
  logic [31:0] if2_rdata;
  logic        d2_ack;
  logic [31:0] d2_rdata;
  logic        mem2_read;
  logic [1:0]  mem2_write;
  logic [11:0] mem2_addr;
  logic [31:0] bus2_out;
  logic        bus2_oe;
  logic [31:0] bus2_in;
  logic        busy2;

  logic [31:0] phys [4096];
  logic [31:0] refm [4096];
  logic [31:0] exp_if_rd, exp_d_rd;
  bit          last_d;
  int          cyc = 0;
  int          ack_cyc;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign bus_in  = mem_read ? phys[mem_addr] : 32'h0BAD_0BAD;
  assign bus2_in = mem2_read ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if2_req), .if_addr(if2_addr),
    .if_ack(if2_ack), .if_rdata(if2_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0),
    .d_addr(12'd0), .d_wdata(32'd0),
    .d_ack(d2_ack), .d_rdata(d2_rdata),
    .mem_read(mem2_read), .mem_write(mem2_write),
    .mem_addr(mem2_addr), .bus_out(bus2_out),
    .bus_oe(bus2_oe), .bus_in(bus2_in), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory commits writes mid-cycle; inputs/samples land 1 after the edge
  task automatic tick;
    @(negedge clk);
    if (mem_write == 2'd3) phys[mem_addr][7:0] = bus_out[7:0];
    else if (mem_write == 2'd1) phys[mem_addr] = bus_out;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_chk;
    chk("idle", {busy, if_ack, d_ack, mem_read, mem_write, bus_oe}, 64'd0);
    tick;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk("rst_ctl", {busy, if_ack, d_ack, mem_read, mem_write, bus_oe, mem_addr}, 64'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    chk("rst_bus", bus_out, 64'd0);
    tick;
    chk("rst_noack", {if_ack, d_ack, if2_ack, busy2}, 64'd0);
    tick;
    rst = 1'b0;
    exp_if_rd = 32'd0;
    exp_d_rd  = 32'd0;
    last_d    = 1'b0;
  endtask

  // Entered in an IDLE cycle with requests applied; returns in the next IDLE cycle.
  task automatic serve(input bit rehold, input bit chg, input logic [11:0] chg_addr);
    bit          pd, wr, by;
    logic [11:0] a;
    logic [31:0] wd;
    pd = (if_req && d_req) ? !last_d : d_req;
    a  = pd ? d_addr : if_addr;
    wr = pd && d_we;
    by = d_byte;
    wd = d_wdata;
    tick;
    for (int c = 1; c <= LAT; c++) begin
      if (c == 2 && chg) begin
        if (pd) d_addr = chg_addr;
        else if_addr = chg_addr;
      end
      chk("window", {busy, if_ack, d_ack, mem_read, mem_write, bus_oe, mem_addr},
          {1'b1, 1'b0, 1'b0, !wr, wr ? (by ? 2'd3 : 2'd1) : 2'd0, wr, a});
      if (wr) chk("bus_out", bus_out, wd);
      tick;
    end
    chk("ack", {busy, if_ack, d_ack, mem_read, mem_write, bus_oe},
        {1'b1, !pd, pd, 1'b0, 2'd0, 1'b0});
    if (wr) begin
      if (by) refm[a][7:0] = wd[7:0];
      else refm[a] = wd;
    end else if (pd) begin
      exp_d_rd = refm[a];
    end else begin
      exp_if_rd = refm[a];
    end
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("d_rdata", d_rdata, exp_d_rd);
    last_d  = pd;
    ack_cyc = cyc;
    if (!rehold) begin
      if (pd) d_req = 1'b0;
      else if_req = 1'b0;
    end
    tick;
  endtask

  initial begin
    int a1, a2, a3, a4;
    for (int i = 0; i < 4096; i++) begin
      phys[i] = $urandom;
      refm[i] = phys[i];
    end
    phys[12'h010] = 32'hDEAD_BEEF;
    refm[12'h010] = 32'hDEAD_BEEF;

    do_reset;
    idle_chk;

    if_addr = 12'h010;
    if_req  = 1'b1;
    serve(0, 0, 12'd0);
    chk("fetch_data", if_rdata, 64'hDEAD_BEEF);

    d_we = 1'b1; d_byte = 1'b0; d_addr = 12'h021; d_wdata = 32'h1122_3344;
    d_req = 1'b1;
    serve(0, 0, 12'd0);

    d_we = 1'b0; d_addr = 12'h021; d_req = 1'b1;
    serve(0, 0, 12'd0);
    chk("readback", d_rdata, 64'h1122_3344);

    d_we = 1'b1; d_byte = 1'b1; d_addr = 12'h022; d_wdata = 32'h0000_00AB;
    d_req = 1'b1;
    serve(0, 0, 12'd0);
    d_byte = 1'b0; d_we = 1'b0; d_req = 1'b1;
    serve(0, 0, 12'd0);

    do_reset;
    if_addr = 12'h030; d_addr = 12'h031; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    serve(1, 0, 12'd0); a1 = ack_cyc;
    chk("order1", d_rdata, refm[12'h031]);
    serve(1, 0, 12'd0); a2 = ack_cyc;
    chk("order2", if_rdata, refm[12'h030]);
    serve(0, 0, 12'd0); a3 = ack_cyc;
    serve(0, 0, 12'd0); a4 = ack_cyc;
    chk("ack_gap1", a2 - a1, LAT + 2);
    chk("ack_gap2", a3 - a2, LAT + 2);
    chk("ack_gap3", a4 - a3, LAT + 2);

    d_we = 1'b1; d_addr = 12'h050; d_wdata = 32'h5A5A_1234; d_req = 1'b1;
    tick;
    tick;
    chk("pre_abort", {mem_write, bus_oe}, 64'b011);
    do_reset;
    serve(0, 0, 12'd0);
    d_we = 1'b0; d_req = 1'b1;
    serve(0, 0, 12'd0);
    chk("reissued", d_rdata, 64'h5A5A_1234);

    d_addr = 12'h021; d_req = 1'b1;
    serve(0, 1, 12'h0FF);

    for (int i = 0; i < 40; i++) begin
      int mode, gaps;
      bit chg;
      mode = $urandom_range(0, 2);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle_chk;
      if_addr = 12'h040 + 12'($urandom_range(0, 7));
      d_addr  = 12'h040 + 12'($urandom_range(0, 7));
      d_we    = 1'($urandom_range(0, 1));
      d_byte  = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      chg     = 1'($urandom_range(0, 1));
      if_req  = (mode != 1);
      d_req   = (mode != 0);
      serve(0, chg, 12'($urandom_range(0, 4095)));
      if (if_req || d_req) serve(0, 0, 12'd0);
    end
    idle_chk;

    if2_addr = 12'h0AA;
    if2_req  = 1'b1;
    tick;
    chk("l2_c1", {busy2, if2_ack, mem2_read, mem2_write, bus2_oe, mem2_addr},
        {1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 12'h0AA});
    tick;
    chk("l2_c2", {busy2, if2_ack, mem2_read}, 64'b101);
    tick;
    chk("l2_ack", {busy2, if2_ack, d2_ack, mem2_read}, 64'b1100);
    chk("l2_rdata", if2_rdata, 64'hCAFE_F00D);
    chk("l2_quiet", {d2_rdata, bus2_out}, 64'd0);
    if2_req = 1'b0;
    tick;
    chk("l2_idle", {busy2, if2_ack}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
